// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for the single memory port.
// One transaction in flight; LSU priority with a fetch starvation guard.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [63:0] if_resp_rdata,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [63:0] ls_req_addr,
    input  logic        ls_req_wen,
    input  logic [63:0] ls_req_wdata,
    input  logic [7:0]  ls_req_wmask,
    output logic        ls_resp_valid,
    output logic [63:0] ls_resp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] starve_cnt;
    logic       grant_if;
    logic       grant_ls;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (grant_if || grant_ls) state_nx = REQ;
            REQ:  if (mem_req_ready) state_nx = RESP;
            RESP: if (mem_resp_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Readies are gated by reset so every output reads 0 while held in reset.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE && !reset) begin
            if (ls_req_valid && if_req_valid) begin
                if (starve_cnt == LIMIT) grant_if = 1'b1;
                else grant_ls = 1'b1;
            end else if (ls_req_valid) begin
                grant_ls = 1'b1;
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end
        end
        if_req_ready  = grant_if;
        ls_req_ready  = grant_ls;
        mem_req_valid = (state == REQ);
        busy          = (state != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner         <= 1'b0;
            starve_cnt    <= 4'd0;
            mem_req_addr  <= 64'd0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= 64'd0;
            mem_req_wmask <= 8'd0;
            if_resp_valid <= 1'b0;
            if_resp_rdata <= 64'd0;
            ls_resp_valid <= 1'b0;
            ls_resp_rdata <= 64'd0;
        end else begin
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            if (grant_ls) begin
                owner         <= 1'b1;
                mem_req_addr  <= ls_req_addr;
                mem_req_wen   <= ls_req_wen;
                mem_req_wdata <= ls_req_wdata;
                mem_req_wmask <= ls_req_wmask;
                if (if_req_valid && starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end
            if (grant_if) begin
                owner         <= 1'b0;
                mem_req_addr  <= if_req_addr;
                mem_req_wen   <= 1'b0;
                mem_req_wdata <= 64'd0;
                mem_req_wmask <= 8'd0;
                starve_cnt    <= 4'd0;
            end
            if (state == RESP && mem_resp_valid) begin
                if (owner) begin
                    ls_resp_rdata <= mem_resp_rdata;
                    ls_resp_valid <= 1'b1;
                end else begin
                    if_resp_rdata <= mem_resp_rdata;
                    if_resp_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: queued requesters, a memory model and
// a response scoreboard.
module tb_mem_arbiter;

    localparam int LIM = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [63:0] if_req_addr = 64'd0;
    logic        if_resp_valid;
    logic [63:0] if_resp_rdata;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic [63:0] ls_req_addr = 64'd0;
    logic        ls_req_wen = 1'b0;
    logic [63:0] ls_req_wdata = 64'd0;
    logic [7:0]  ls_req_wmask = 8'd0;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_rdata = 64'd0;
    logic        busy;
    logic        owner;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
        .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
        .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } ls_t;

    typedef struct {
        logic        own;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } mexp_t;

    typedef struct {
        logic        own;
        logic [63:0] rdata;
    } rexp_t;

    logic [63:0] if_q[$];
    ls_t         ls_q[$];
    mexp_t       exp_mem[$];
    rexp_t       exp_resp[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mdata(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h13;
        return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
    endfunction

    // Requesters: hold valid until accepted, then present the next entry.
    logic if_fire = 1'b0;
    logic ls_fire = 1'b0;

    always @(posedge clock) begin
        #1;
        if (if_fire && if_q.size() > 0) void'(if_q.pop_front());
        if (ls_fire && ls_q.size() > 0) void'(ls_q.pop_front());
        if_req_valid = (if_q.size() > 0);
        if_req_addr  = if_req_valid ? if_q[0] : 64'd0;
        ls_req_valid = (ls_q.size() > 0);
        ls_req_addr  = ls_req_valid ? ls_q[0].addr : 64'd0;
        ls_req_wen   = ls_req_valid ? ls_q[0].wen : 1'b0;
        ls_req_wdata = ls_req_valid ? ls_q[0].wdata : 64'd0;
        ls_req_wmask = ls_req_valid ? ls_q[0].wmask : 8'd0;
    end

    // Grant / starvation / response monitor.
    int starve_m = 0;
    int if_acc_cyc = 0;
    int if_resp_cyc = 0;
    int ls_resp_cyc = 0;
    int if_resp_n = 0;
    int ls_resp_n = 0;

    always @(negedge clock) begin
        rexp_t r;
        if_fire = if_req_valid && if_req_ready;
        ls_fire = ls_req_valid && ls_req_ready;
        if (reset) starve_m = 0;
        if (if_req_ready || ls_req_ready)
            chk("one_grant", 64'(if_req_ready & ls_req_ready), 64'd0);
        if (ls_fire) begin
            chk("starve_at_ls", 64'(dut.starve_cnt), 64'(starve_m));
            if (if_req_valid && starve_m < LIM) starve_m++;
        end
        if (if_fire) begin
            chk("starve_at_if", 64'(dut.starve_cnt), 64'(starve_m));
            starve_m = 0;
            if_acc_cyc = cyc;
        end
        if (if_resp_valid || ls_resp_valid) begin
            if (exp_resp.size() == 0) begin
                chk("resp_unexpected",
                    64'({if_resp_valid, ls_resp_valid}), 64'd0);
            end else begin
                r = exp_resp.pop_front();
                chk("resp_both", 64'(if_resp_valid & ls_resp_valid), 64'd0);
                chk("resp_owner", 64'(ls_resp_valid), 64'(r.own));
                chk("resp_rdata",
                    r.own ? ls_resp_rdata : if_resp_rdata, r.rdata);
            end
            if (if_resp_valid) begin
                if_resp_n++;
                if_resp_cyc = cyc;
            end
            if (ls_resp_valid) begin
                ls_resp_n++;
                ls_resp_cyc = cyc;
            end
        end
    end

    // Memory model: optional stall, optional stray response during REQ.
    int          stall = 0;
    bit          spur = 0;
    int          stall_seen = 0;
    int          memv_n = 0;
    int          mem_acc_cyc = 0;
    bit          pend = 0;
    logic        pend_own = 1'b0;
    logic [63:0] pend_d = 64'd0;

    always @(negedge clock) begin
        mexp_t m;
        if (reset) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            pend = 0;
        end else begin
            mem_resp_valid = 1'b0;
            if (pend) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = pend_d;
                exp_resp.push_back('{own: pend_own, rdata: pend_d});
                pend = 0;
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                memv_n++;
                chk("req_busy", 64'(busy), 64'd1);
                chk("req_no_ready", 64'({if_req_ready, ls_req_ready}), 64'd0);
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected", 64'(mem_req_valid), 64'd0);
                end else begin
                    m = exp_mem[0];
                    chk("mem_addr", mem_req_addr, m.addr);
                    chk("mem_wen", 64'(mem_req_wen), 64'(m.wen));
                    chk("mem_wdata", mem_req_wdata, m.wdata);
                    chk("mem_wmask", 64'(mem_req_wmask), 64'(m.wmask));
                    chk("mem_owner", 64'(owner), 64'(m.own));
                    if (stall > 0) begin
                        stall_seen++;
                        if (spur && stall == 3) begin
                            mem_resp_valid = 1'b1;
                            mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                        end
                        stall--;
                    end else begin
                        mem_req_ready = 1'b1;
                        void'(exp_mem.pop_front());
                        pend     = 1;
                        pend_own = m.own;
                        pend_d   = mdata(m.addr);
                        mem_acc_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic push_if(input logic [63:0] a);
        if_q.push_back(a);
        exp_mem.push_back('{own: 1'b0, addr: a, wen: 1'b0,
                           wdata: 64'd0, wmask: 8'd0});
    endtask

    task automatic push_ls(input logic [63:0] a, input logic w,
                           input logic [63:0] d, input logic [7:0] mk);
        ls_q.push_back('{addr: a, wen: w, wdata: d, wmask: mk});
    endtask

    task automatic exp_ls(input logic [63:0] a, input logic w,
                          input logic [63:0] d, input logic [7:0] mk);
        exp_mem.push_back('{own: 1'b1, addr: a, wen: w,
                           wdata: d, wmask: mk});
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clock);
            done = if_q.size() == 0 && ls_q.size() == 0 &&
                   exp_mem.size() == 0 && exp_resp.size() == 0 &&
                   !pend && !busy && !if_req_valid && !ls_req_valid;
        end
        chk({tag, "_timeout"}, 64'(!done), 64'd0);
        if (!done) begin
            if_q.delete();
            ls_q.delete();
            exp_mem.delete();
            exp_resp.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_ready"}, 64'(if_req_ready), 64'd0);
        chk({tag, "_ls_ready"}, 64'(ls_req_ready), 64'd0);
        chk({tag, "_if_resp_v"}, 64'(if_resp_valid), 64'd0);
        chk({tag, "_ls_resp_v"}, 64'(ls_resp_valid), 64'd0);
        chk({tag, "_if_rdata"}, if_resp_rdata, 64'd0);
        chk({tag, "_ls_rdata"}, ls_resp_rdata, 64'd0);
        chk({tag, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "_mem_addr"}, mem_req_addr, 64'd0);
        chk({tag, "_mem_wen"}, 64'(mem_req_wen), 64'd0);
        chk({tag, "_mem_wdata"}, mem_req_wdata, 64'd0);
        chk({tag, "_mem_wmask"}, 64'(mem_req_wmask), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_owner"}, 64'(owner), 64'd0);
    endtask

    initial begin
        int memv0;
        int lsr0;
        int ifr0;
        bit hit;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk_all_zero("rst");
        reset = 1'b0;

        // Single fetch at minimum latency.
        memv0 = memv_n;
        lsr0  = ls_resp_n;
        push_if(64'h8000_0000);
        wait_idle("t1");
        chk("t1_mem_lat", 64'(mem_acc_cyc - if_acc_cyc), 64'd1);
        chk("t1_resp_lat", 64'(if_resp_cyc - if_acc_cyc), 64'd3);
        chk("t1_memv_cycles", 64'(memv_n - memv0), 64'd1);
        chk("t1_ls_silent", 64'(ls_resp_n - lsr0), 64'd0);
        chk("t1_rdata", if_resp_rdata, 64'h13);

        // Simultaneous store and fetch: store goes first.
        push_ls(64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F);
        exp_ls(64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F);
        push_if(64'h8000_0200);
        wait_idle("t2");
        chk("t2_order", 64'(ls_resp_cyc < if_resp_cyc), 64'd1);
        chk("t2_ls_rdata", ls_resp_rdata, mdata(64'h8000_1000));
        chk("t2_if_rdata", if_resp_rdata, mdata(64'h8000_0200));

        // Starvation guard: L,L,L,L,F,L,L,L,L,F.
        for (int i = 0; i < 8; i++) begin
            push_ls(64'h1000 + 64'(i * 8), 1'b0, 64'd0, 8'd0);
        end
        if_q.push_back(64'h8000_0100);
        if_q.push_back(64'h8000_0104);
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                exp_mem.push_back('{own: 1'b0,
                    addr: (i == 4) ? 64'h8000_0100 : 64'h8000_0104,
                    wen: 1'b0, wdata: 64'd0, wmask: 8'd0});
            end else begin
                exp_ls(64'h1000 + 64'(((i < 4) ? i : i - 1) * 8),
                       1'b0, 64'd0, 8'd0);
            end
        end
        wait_idle("t3");
        chk("t3_starve_end", 64'(dut.starve_cnt), 64'd0);

        // Memory stall with a stray response during REQ.
        stall_seen = 0;
        stall = 5;
        spur  = 1;
        lsr0  = ls_resp_n;
        ifr0  = if_resp_n;
        push_ls(64'h2000, 1'b0, 64'd0, 8'd0);
        exp_ls(64'h2000, 1'b0, 64'd0, 8'd0);
        push_if(64'h8000_0300);
        wait_idle("t4");
        spur = 0;
        chk("t4_stall_cycles", 64'(stall_seen), 64'd5);
        chk("t4_ls_one_resp", 64'(ls_resp_n - lsr0), 64'd1);
        chk("t4_if_one_resp", 64'(if_resp_n - ifr0), 64'd1);
        chk("t4_ls_rdata", ls_resp_rdata, mdata(64'h2000));

        // Reset while in RESP drops the response.
        ifr0 = if_resp_n;
        push_if(64'h8000_0400);
        hit = 0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clock);
            hit = busy && !mem_req_valid;
        end
        chk("t5_reach_resp", 64'(hit), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("t5");
        exp_resp.delete();
        exp_mem.delete();
        reset = 1'b0;
        @(negedge clock);
        chk("t5_no_pulse", 64'(if_resp_valid), 64'd0);
        chk("t5_no_count", 64'(if_resp_n - ifr0), 64'd0);
        push_if(64'h8000_0500);
        wait_idle("t5b");
        chk("t5_after_rdata", if_resp_rdata, mdata(64'h8000_0500));
        chk("t5_after_count", 64'(if_resp_n - ifr0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
